// File: rtl/cdc_pulse_pkg.sv
// Shared constants for the toggle-handshake pulse CDC (receiver and sender sides).
package cdc_pulse_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PEND_W_DEFAULT  = 4;

  function automatic bit sync_stages_legal(input int stages);
    return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous reset; pure flop chain, no logic between stages.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_pulse_rx.sv
// Receiver side of the toggle-handshake pulse CDC: sync, edge detect, ack return, queued pulse delivery.
// Build option: define CDC_PULSE_RX_ACK_ON_DELIVER_EN to acknowledge on delivery instead of on detection.
module cdc_pulse_rx
  import cdc_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = PEND_W_DEFAULT
) (
  input  logic              receiver_clk_i,
  input  logic              receiver_reset_i,
  input  logic              req_toggle_i,
  output logic              ack_toggle_o,
  input  logic              receiver_ready_i,
  output logic              receiver_pulse_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("cdc_pulse_rx: SYNC_STAGES must lie in 2..4");
  end

  // Saturating queue update; the MSB of the result flags a dropped event.
  function automatic logic [PEND_W:0] pend_update(
    input logic [PEND_W-1:0] cur,
    input logic              evt,
    input logic              emt
  );
    logic [PEND_W-1:0] full;
    full = '1;
    if (evt && !emt) begin
      if (cur == full) return {1'b1, cur};
      return {1'b0, cur + 1'b1};
    end else if (!evt && emt) begin
      return {1'b0, cur - 1'b1};
    end
    return {1'b0, cur};
  endfunction

  logic              req_sync;
  logic              req_prev;
  logic              req_edge;
  logic              emit;
  logic              drop;
  logic [PEND_W-1:0] pend_nxt;

  // Stage p0: synchronize the asynchronous request toggle
  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk (receiver_clk_i),
    .rst (receiver_reset_i),
    .d   (req_toggle_i),
    .q   (req_sync)
  );

  // Stage p1: edge detect, delivery decision and queue bookkeeping
  assign req_edge = req_sync ^ req_prev;
  assign emit     = receiver_ready_i & ((pending_o != '0) | req_edge);

  always_comb begin
    {drop, pend_nxt} = pend_update(pending_o, req_edge, emit);
  end

  always_ff @(posedge receiver_clk_i) begin
    if (receiver_reset_i) begin
      req_prev         <= 1'b0;
      ack_toggle_o     <= 1'b0;
      receiver_pulse_o <= 1'b0;
      pending_o        <= '0;
      overflow_o       <= 1'b0;
    end else begin
      req_prev         <= req_sync;
      receiver_pulse_o <= emit;
      pending_o        <= pend_nxt;
      if (drop) overflow_o <= 1'b1;
`ifdef CDC_PULSE_RX_ACK_ON_DELIVER_EN
      if (emit) ack_toggle_o <= ~ack_toggle_o;
`else
      // Ack tracks every detected event, even a dropped one, so the sender never stalls.
      if (req_edge) ack_toggle_o <= req_sync;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_pulse_rx.sv
// Self-checking bench for cdc_pulse_rx: directed scenarios plus randomized traffic against an event-queue model.
module tb_cdc_pulse_rx;

  localparam int S    = 2;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          ready;
  logic          ack;
  logic          pulse;
  logic [PW-1:0] pending;
  logic          ovf;

  int   checks = 0;
  int   passed = 0;
  int   samp[$];
  int   m_pend, m_ovf, m_pulse, m_ack;
  int   pulse_cnt, ack_flips, base;
  logic ack_last;

  cdc_pulse_rx #(
    .SYNC_STAGES (S),
    .PEND_W      (PW)
  ) dut (
    .receiver_clk_i   (clk),
    .receiver_reset_i (rst),
    .req_toggle_i     (req),
    .ack_toggle_o     (ack),
    .receiver_ready_i (ready),
    .receiver_pulse_o (pulse),
    .pending_o        (pending),
    .overflow_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: an event is the req level seen S edges ago differing from the one before it;
  // events join a queue of capacity PMAX and leave one per ready cycle.
  task automatic model_edge();
    int  lvl_new, lvl_old;
    bit  evt, emt;
    if (rst) begin
      samp.delete();
      repeat (S + 1) samp.push_back(0);
      m_pend = 0; m_ovf = 0; m_pulse = 0; m_ack = 0;
      return;
    end
    lvl_new = samp[samp.size() - S];
    lvl_old = samp[samp.size() - S - 1];
    evt = (lvl_new != lvl_old);
    emt = ready && (m_pend > 0 || evt);
`ifdef CDC_PULSE_RX_ACK_ON_DELIVER_EN
    if (emt) m_ack = 1 - m_ack;
`else
    if (evt) m_ack = lvl_new;
`endif
    if (evt && !emt) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end else if (!evt && emt) begin
      m_pend--;
    end
    m_pulse = emt;
    samp.push_back(int'(req));
    if (samp.size() > S + 1) void'(samp.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pulse", pulse, m_pulse);
    chk("ack", ack, m_ack);
    chk("pending", pending, m_pend);
    chk("overflow", ovf, m_ovf);
    if (pulse === 1'b1) pulse_cnt++;
    if (ack !== ack_last) ack_flips++;
    ack_last = ack;
    @(negedge clk);
  endtask

  initial begin
    repeat (S + 1) samp.push_back(0);
    m_pend = 0; m_ovf = 0; m_pulse = 0; m_ack = 0;
    pulse_cnt = 0; ack_flips = 0; ack_last = 1'b0;
    rst = 1'b1; req = 1'b0; ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", ovf, 0);
    rst = 1'b0;
    tick();

    // Single toggle, ready high: pulse after S+1 edges
    req = 1'b1;
    tick(); chk("lat_e1", pulse, 0);
    tick(); chk("lat_e2", pulse, 0);
    tick(); chk("lat_e3_pulse", pulse, 1); chk("lat_e3_ack", ack, 1);
    tick(); chk("lat_e4_pulse", pulse, 0); chk("lat_pending", pending, 0);

    // Five events while stalled, then drain back-to-back
    ready = 1'b0;
    base = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      req = ~req;
      repeat (4) tick();
    end
    chk("stall_pending", pending, 5);
    chk("stall_no_pulse", pulse_cnt - base, 0);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("drain_pulse", pulse, 1);
    end
    tick();
    chk("drain_end_pulse", pulse, 0);
    chk("drain_pending", pending, 0);

    // Saturation: 16 events into a 15-deep queue
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    ready = 1'b0;
    ack_flips = 0;
    for (int i = 0; i < 16; i++) begin
      req = ~req;
      repeat (3) tick();
    end
    repeat (3) tick();
    chk("sat_pending", pending, PMAX);
    chk("sat_overflow", ovf, 1);
`ifdef CDC_PULSE_RX_ACK_ON_DELIVER_EN
    chk("sat_ack_flips", ack_flips, 0);
`else
    chk("sat_ack_flips", ack_flips, 16);
`endif

    // Event detected on the same cycle a queued pulse leaves
    rst = 1'b1; req = 1'b0; repeat (2) tick(); rst = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req = ~req;
      repeat (4) tick();
    end
    chk("bypass_pre", pending, 2);
    base = pulse_cnt;
    req = ~req;
    repeat (2) tick();
    ready = 1'b1;
    tick();
    chk("bypass_pending", pending, 2);
    chk("bypass_pulse", pulse, 1);
    ready = 1'b0;
    tick();
    chk("bypass_hold", pending, 2);
    ready = 1'b1;
    repeat (3) tick();
    chk("bypass_drained", pending, 0);
    chk("bypass_count", pulse_cnt - base, 3);

    // Reset with a non-empty queue and req high
    rst = 1'b1; req = 1'b0; repeat (2) tick(); rst = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = ~req;
      repeat (4) tick();
    end
    chk("mid_pending", pending, 3);
    rst = 1'b1;
    tick();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_pulse", pulse, 0);
    chk("mid_rst_overflow", ovf, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_pending", pending, 1);
`ifdef CDC_PULSE_RX_ACK_ON_DELIVER_EN
    chk("post_rst_ack", ack, 0);
`else
    chk("post_rst_ack", ack, 1);
`endif

`ifdef CDC_PULSE_RX_ACK_ON_DELIVER_EN
    // Ack held back until the event is actually delivered
    rst = 1'b1; req = 1'b0; repeat (2) tick(); rst = 1'b0;
    ready = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("deliver_ack_hold", ack, 0);
    end
    ready = 1'b1;
    tick();
    chk("deliver_pulse", pulse, 1);
    chk("deliver_ack", ack, 1);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) req = ~req;
      ready = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    ready = 1'b1;
    repeat (PMAX + S + 2) tick();
    chk("final_drained", pending, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_rx.md
Name: cdc_pulse_rx

Overview:
- Receiver end of the toggle-handshake pulse-CDC protocol, living entirely in the receiver clock domain.
- Synchronizes the sender's request toggle and detects each level change as one event.
- Returns an acknowledge toggle to the sender and delivers each event as a single-cycle pulse, gated by a downstream ready.
- Events arriving while downstream is stalled are queued in a saturating pending counter, with sticky overflow reporting.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on req_toggle_i; legal range 2..4.
- PEND_W, 4, width of the pending-event counter; queue capacity is 2^PEND_W-1 events.

Ports:
- receiver_clk_i  input  1  receiver-domain clock; the only clock in the block.
- receiver_reset_i  input  1  reset; synchronous, active-high.
- req_toggle_i  input  1  request toggle from sender domain; asynchronous; each level change is one event.
- ack_toggle_o  output  1  acknowledge toggle returned to sender; registered; mirrors the accepted request level.
- receiver_ready_i  input  1  downstream can accept a pulse this cycle.
- receiver_pulse_o  output  1  one-cycle event pulse; registered.
- pending_o  output  PEND_W  events detected but not yet delivered.
- overflow_o  output  1  sticky; set when an event is dropped because the queue is full.

Behaviour:
- Reset (synchronous, active-high): synchronizer chain, req_prev, ack_toggle_o, receiver_pulse_o, pending_o and overflow_o all go to 0.
- Synchronizer: req_toggle_i passes through SYNC_STAGES flops; req_sync is the last stage. No logic is placed between the stages.
- Edge detection: req_prev <= req_sync every cycle; edge = req_sync ^ req_prev (combinational).
- Acknowledge (default build): ack_toggle_o <= req_sync whenever edge=1, so ack toggles one cycle after the edge is detected.
- Emit: emit = receiver_ready_i & (pending_o != 0 | edge); receiver_pulse_o <= emit.
- Pending update: pending_next = pending_o + edge - emit.
  - edge and emit together: pending unchanged (bypass path).
  - pending_o at max (all ones), edge=1, emit=0: event dropped, pending unchanged, overflow_o <= 1. ack still toggles so the sender never deadlocks.
- Latency with empty queue and ready held high: the pulse appears SYNC_STAGES+1 receiver_clk edges after the first edge that samples the new req level (3 edges at default).
- Back-to-back delivery: while pending_o != 0 and ready=1, one pulse is issued every cycle.
- receiver_ready_i low: no pulses are issued; events accumulate in pending_o.
- overflow_o clears only on reset.
- Reset mid-operation: queued events are discarded. Sender and receiver resets must be co-asserted. If req_toggle_i is 1 after reset release, this is by definition one event, and ack_toggle_o follows it to 1.

Optional Feature:
- Macro: CDC_PULSE_RX_ACK_ON_DELIVER_EN.
- Defined:
  - ack_toggle_o toggles only when an event is delivered: ack_toggle_o <= ~ack_toggle_o on emit.
  - The sender therefore sees end-to-end flow control, and pending_o never exceeds 1 for a compliant sender.
  - overflow_o still sets if a non-compliant sender toggles req twice without waiting for ack.
- Undefined: the default acknowledge-on-detect behaviour above.

Decomposition:
- Package cdc_pulse_pkg holds:
  - SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4, checked by an elaboration-time assertion.
  - Default PEND_W.
  - Shared with the future sender-side block.
- Sub-module cdc_sync_bit (parameter STAGES, synchronous-reset flop chain) implements the synchronizer and is reused by the sender for the ack path.

Test Plan:
- Reset, then a single req toggle 0->1 with ready=1 -> exactly one receiver_pulse_o 3 cycles after sampling; ack_toggle_o=1 on the cycle after detection; pending_o stays 0.
- ready=0, then 5 req toggles spaced 4 cycles apart -> pending_o=5 and no pulses; after raising ready, 5 consecutive single-cycle pulses and pending_o back to 0.
- ready=0, then 16 toggles with PEND_W=4 -> pending_o saturates at 15, overflow_o=1, and ack_toggle_o has toggled 16 times.
- Toggle arriving on the same cycle a queued pulse is emitted (pending=2) -> pending_o stays 2, with no lost or duplicate pulse.
- receiver_reset_i asserted with pending_o=3 and req=1 -> all outputs 0 during reset; after release, one event is detected (req=1) and ack_toggle_o goes to 1.
- With CDC_PULSE_RX_ACK_ON_DELIVER_EN and ready held low for 10 cycles after a toggle -> ack_toggle_o does not change until the pulse is emitted, then toggles on the same cycle that receiver_pulse_o is high.
